// File: rtl/bithash_frame_pkg.sv
// rtl/bithash_frame_pkg.sv - shared constants and types for the result frame decoder
// Purpose: word-format field positions, word types, frame geometry, error codes
//          and FSM state encoding used by result_frame_decoder and its field decoder.
// Ports:   none (package).
package bithash_frame_pkg;

  // 48-bit FIFO word: [47]=reserved(0), [46:44]=type, [43:40]=index, [39:0]=payload
  localparam int RSVD_BIT  = 47;
  localparam int TYPE_MSB  = 46;
  localparam int TYPE_LSB  = 44;
  localparam int IDX_MSB   = 43;
  localparam int IDX_LSB   = 40;
  localparam int PAYLOAD_W = 40;

  localparam logic [2:0] TYPE_HASH  = 3'b001;
  localparam logic [2:0] TYPE_NONCE = 3'b010;

  // 6 full 40-bit hash words plus a 16-bit tail in word 7 make up 256 bits
  localparam int HASH_WORDS  = 7;
  localparam int TAIL_W      = 16;
  localparam int HASH_PAD_W  = PAYLOAD_W - TAIL_W;
  localparam int NONCE_PAD_W = 8;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_HDR  = 2'b01,
    ERR_SEQ  = 2'b10,
    ERR_PAD  = 2'b11
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXP_HASH,
    ST_EXP_NONCE,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/result_frame_field_dec.sv
// rtl/result_frame_field_dec.sv - combinational field split and header check of one result word
// Purpose: splits a FIFO word into index/payload and classifies it.
// Ports:   datain  - 48-bit FIFO word
//          index   - word index field
//          payload - 40-bit payload field
//          is_hash / is_nonce - reserved bit clear and type matches
//          hdr_ok  - well-formed header (hash idx 1..7, nonce idx 1)
//          pad_ok  - padding bits zero (always 1 unless PAD_CHECK_EN is defined)
// Build option: PAD_CHECK_EN enables the padding check.
module result_frame_field_dec
  import bithash_frame_pkg::*;
(
  input  logic [47:0]          datain,
  output logic [3:0]           index,
  output logic [PAYLOAD_W-1:0] payload,
  output logic                 is_hash,
  output logic                 is_nonce,
  output logic                 hdr_ok,
  output logic                 pad_ok
);

  logic       rsvd;
  logic [2:0] wtype;

  always_comb begin
    rsvd     = datain[RSVD_BIT];
    wtype    = datain[TYPE_MSB:TYPE_LSB];
    index    = datain[IDX_MSB:IDX_LSB];
    payload  = datain[PAYLOAD_W-1:0];
    is_hash  = !rsvd && (wtype == TYPE_HASH);
    is_nonce = !rsvd && (wtype == TYPE_NONCE);
    hdr_ok   = (is_hash && (index != 4'd0) && (index <= 4'(HASH_WORDS)))
            || (is_nonce && (index == 4'd1));
`ifdef PAD_CHECK_EN
    pad_ok   = !((is_hash && (index == 4'(HASH_WORDS)) && (payload[HASH_PAD_W-1:0] != '0))
            || (is_nonce && (payload[NONCE_PAD_W-1:0] != '0)));
`else
    pad_ok   = 1'b1;
`endif
  end

endmodule

// File: rtl/result_frame_decoder.sv
// rtl/result_frame_decoder.sv - reassembles 7 hash words + 1 nonce word into a result frame
// Purpose: pops the result FIFO, checks header and sequence of each word, rebuilds the
//          256-bit hash and 32-bit nonce and holds the finished result on a valid/ready port.
// Ports:   clk, rst_n (async active-low)
//          fifo_empty, fifo_rden, datain - FIFO read side, data valid 1 cycle after rden
//          res_valid, res_ready, hash_out, nonce_out - result handshake
//          err_pulse, err_code, err_count - word rejection reporting (count saturates)
// Build option: PAD_CHECK_EN (padding check, error code 11) in result_frame_field_dec.
module result_frame_decoder
  import bithash_frame_pkg::*;
#(
  parameter int HASH     = 256,
  parameter int NONCE    = 32,
  parameter int DATAIN   = 48,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fifo_empty,
  output logic                fifo_rden,
  input  logic [DATAIN-1:0]   datain,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [HASH-1:0]     hash_out,
  output logic [NONCE-1:0]    nonce_out,
  output logic                err_pulse,
  output logic [1:0]          err_code,
  output logic [ERRCNT_W-1:0] err_count
);

  state_e               state_q, state_d;
  logic [3:0]           exp_q, exp_d;
  logic                 rd_pending;
  logic [HASH-1:0]      hash_acc;
  logic                 err_d;
  err_code_e            code_d;
  logic                 accept_hash;
  logic                 complete;

  logic [3:0]           index;
  logic [PAYLOAD_W-1:0] payload;
  logic                 is_hash, is_nonce, hdr_ok, pad_ok;

  result_frame_field_dec u_field_dec (
    .datain   (datain),
    .index    (index),
    .payload  (payload),
    .is_hash  (is_hash),
    .is_nonce (is_nonce),
    .hdr_ok   (hdr_ok),
    .pad_ok   (pad_ok)
  );

  // Once the nonce is in flight nothing more belongs to this frame, so stop
  // popping until the result has been handed off.
  assign fifo_rden = rst_n && !fifo_empty && !res_valid
                  && !(rd_pending && (state_q == ST_EXP_NONCE));

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    err_d       = 1'b0;
    code_d      = ERR_NONE;
    accept_hash = 1'b0;
    complete    = 1'b0;
    if (state_q == ST_HOLD) begin
      if (res_valid && res_ready) state_d = ST_IDLE;
    end else if (rd_pending) begin
      if (!hdr_ok) begin
        err_d   = 1'b1;
        code_d  = ERR_HDR;
        state_d = ST_IDLE;
      end else if (is_hash && (index == 4'd1)) begin
        // A first hash word always (re)starts a frame; mid-frame it also flags the loss.
        accept_hash = 1'b1;
        state_d     = ST_EXP_HASH;
        exp_d       = 4'd2;
        if (state_q != ST_IDLE) begin
          err_d  = 1'b1;
          code_d = ERR_SEQ;
        end
      end else if ((state_q == ST_EXP_HASH) && is_hash && (index == exp_q)) begin
        if (!pad_ok) begin
          err_d   = 1'b1;
          code_d  = ERR_PAD;
          state_d = ST_IDLE;
        end else begin
          accept_hash = 1'b1;
          if (exp_q == 4'(HASH_WORDS)) state_d = ST_EXP_NONCE;
          else                         exp_d   = exp_q + 4'd1;
        end
      end else if ((state_q == ST_EXP_NONCE) && is_nonce) begin
        if (!pad_ok) begin
          err_d   = 1'b1;
          code_d  = ERR_PAD;
          state_d = ST_IDLE;
        end else begin
          complete = 1'b1;
          state_d  = ST_HOLD;
        end
      end else begin
        err_d   = 1'b1;
        code_d  = ERR_SEQ;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      exp_q      <= 4'd0;
      rd_pending <= 1'b0;
      hash_acc   <= '0;
      res_valid  <= 1'b0;
      hash_out   <= '0;
      nonce_out  <= '0;
      err_pulse  <= 1'b0;
      err_code   <= 2'b00;
      err_count  <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      rd_pending <= fifo_rden;
      err_pulse  <= err_d;
      if (err_d) begin
        err_code <= code_d;
        if (err_count != {ERRCNT_W{1'b1}})
          err_count <= err_count + {{(ERRCNT_W-1){1'b0}}, 1'b1};
      end
      if (accept_hash) begin
        for (int k = 1; k < HASH_WORDS; k++) begin
          if (index == 4'(k))
            hash_acc[HASH-1-PAYLOAD_W*(k-1) -: PAYLOAD_W] <= payload;
        end
        if (index == 4'(HASH_WORDS))
          hash_acc[TAIL_W-1:0] <= payload[PAYLOAD_W-1 -: TAIL_W];
      end
      // Outputs change only when a whole frame has been accepted.
      if (complete) begin
        res_valid <= 1'b1;
        hash_out  <= hash_acc;
        nonce_out <= payload[PAYLOAD_W-1 -: NONCE];
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_result_frame_decoder.sv
// tb/tb_result_frame_decoder.sv - directed self-checking bench for result_frame_decoder
module tb_result_frame_decoder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fifo_empty;
  logic         fifo_rden;
  logic [47:0]  datain = '0;
  logic         res_valid;
  logic         res_ready;
  logic [255:0] hash_out;
  logic [31:0]  nonce_out;
  logic         err_pulse;
  logic [1:0]   err_code;
  logic [15:0]  err_count;

  logic         fifo_rden2, res_valid2, err_pulse2;
  logic [255:0] hash_out2;
  logic [31:0]  nonce_out2;
  logic [1:0]   err_code2;
  logic [1:0]   err_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_frame_decoder dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rden(fifo_rden),
    .datain(datain), .res_valid(res_valid), .res_ready(res_ready),
    .hash_out(hash_out), .nonce_out(nonce_out), .err_pulse(err_pulse),
    .err_code(err_code), .err_count(err_count)
  );

  // Narrow-counter copy on identical stimulus, used to observe saturation.
  result_frame_decoder #(.ERRCNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rden(fifo_rden2),
    .datain(datain), .res_valid(res_valid2), .res_ready(res_ready),
    .hash_out(hash_out2), .nonce_out(nonce_out2), .err_pulse(err_pulse2),
    .err_code(err_code2), .err_count(err_count2)
  );

  // FIFO model: data appears on datain the cycle after a pop; flushed by reset.
  logic [47:0] mem [64];
  logic [5:0]  wr_ptr = '0;
  logic [5:0]  rd_ptr = '0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (!rst_n) rd_ptr <= wr_ptr;
    else if (fifo_rden) begin
      datain <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 6'd1;
    end
  end

  // Result / error monitors, sampled on the falling edge.
  int           res_cnt = 0;
  int           err_seen = 0;
  int           hold_viol = 0;
  logic [255:0] res_hash [16];
  logic [31:0]  res_nonce [16];
  logic [1:0]   err_log [64];

  always @(negedge clk) begin
    if (res_valid && res_ready && res_cnt < 16) begin
      res_hash[res_cnt]  = hash_out;
      res_nonce[res_cnt] = nonce_out;
      res_cnt++;
    end
    if (err_pulse && err_seen < 64) begin
      err_log[err_seen] = err_code;
      err_seen++;
    end
    if (fifo_rden && res_valid) hold_viol++;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [47:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  // Hash word k carries hash bits [255-40*(k-1) -: 40]; word 7 carries hash[15:0] then padding.
  task automatic push_frame(input logic [255:0] h, input logic [31:0] n,
                            input logic [7:0] pad, input int skip);
    logic [39:0] p;
    for (int k = 1; k <= 7; k++) begin
      if (k == 7) p = {h[15:0], 24'h0};
      else        p = 40'(h >> (256 - 40*k));
      if (k != skip) push({1'b0, 3'b001, 4'(k), p});
    end
    push({1'b0, 3'b010, 4'd1, n, pad});
  endtask

  task automatic wait_res(input int n, input string tag);
    int cyc = 0;
    while (res_cnt < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 256'(res_cnt), 256'(n));
  endtask

  localparam logic [255:0] H1 = {4{64'h0123456789ABCDEF}};
  localparam logic [255:0] H2 = {4{64'hFEDCBA9876543210}};
  localparam logic [255:0] H3 = {8{32'hA5A50F0F}};
  localparam logic [255:0] H4 = {8{32'h13579BDF}};
  localparam logic [255:0] H5 = {8{32'h2468ACE0}};
  localparam logic [255:0] H6 = {8{32'h0BADF00D}};
  localparam logic [255:0] H7 = {8{32'hC0FFEE11}};

  initial begin
    logic [5:0] lvl;
    logic [5:0] base;
    int         cyc;
    int         base_cnt;

    rst_n     = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_res_valid", 256'(res_valid), 256'(0));
    check("rst_fifo_rden", 256'(fifo_rden), 256'(0));
    check("rst_err_count", 256'(err_count), 256'(0));
    check("rst_err_code",  256'(err_code),  256'(0));
    check("rst_hash_out",  hash_out, 256'(0));
    rst_n = 1'b1;

    // 1: single well-formed frame
    res_ready = 1'b1;
    push_frame(H1, 32'hDEADBEEF, 8'h00, 0);
    wait_res(1, "t1_res_cnt");
    check("t1_hash",      res_hash[0], H1);
    check("t1_nonce",     256'(res_nonce[0]), 256'(32'hDEADBEEF));
    check("t1_err_count", 256'(err_count), 256'(0));
    check("t1_err_pulse", 256'(err_seen), 256'(0));

    // 2: two frames back-to-back with the consumer stalled
    res_ready = 1'b0;
    push_frame(H2, 32'h11112222, 8'h00, 0);
    push_frame(H3, 32'h33334444, 8'h00, 0);
    repeat (20) @(negedge clk);
    lvl = wr_ptr - rd_ptr;
    check("t2_held_valid", 256'(res_valid), 256'(1));
    check("t2_held_hash",  hash_out, H2);
    check("t2_fifo_left",  256'(lvl), 256'(8));
    check("t2_res_cnt",    256'(res_cnt), 256'(1));
    res_ready = 1'b1;
    wait_res(3, "t2_res_cnt_after");
    check("t2_hash2",  res_hash[1], H2);
    check("t2_nonce2", 256'(res_nonce[1]), 256'(32'h11112222));
    check("t2_hash3",  res_hash[2], H3);
    check("t2_nonce3", 256'(res_nonce[2]), 256'(32'h33334444));
    check("t2_no_pop_while_held", 256'(hold_viol), 256'(0));
    lvl = wr_ptr - rd_ptr;
    check("t2_fifo_drained", 256'(lvl), 256'(0));

    // 3: hash idx3 missing -> idx4..nonce rejected as out of sequence, next frame good
    push_frame(H6, 32'h55556666, 8'h00, 3);
    push_frame(H4, 32'h77778888, 8'h00, 0);
    wait_res(4, "t3_res_cnt");
    check("t3_hash",      res_hash[3], H4);
    check("t3_nonce",     256'(res_nonce[3]), 256'(32'h77778888));
    check("t3_err_seen",  256'(err_seen), 256'(5));
    check("t3_first_code", 256'(err_log[0]), 256'(2'b10));
    check("t3_err_count", 256'(err_count), 256'(5));

    // 4: reserved bit set, then illegal type
    push(48'h810000000000);
    push(48'h710000000000);
    repeat (10) @(negedge clk);
    check("t4_err_seen",  256'(err_seen), 256'(7));
    check("t4_code_a",    256'(err_log[5]), 256'(2'b01));
    check("t4_code_b",    256'(err_log[6]), 256'(2'b01));
    check("t4_err_count", 256'(err_count), 256'(7));
    check("t4_res_valid", 256'(res_valid), 256'(0));

    // 5: nonce padding byte nonzero
    push_frame(H5, 32'h9ABCDEF0, 8'h5A, 0);
`ifdef PAD_CHECK_EN
    repeat (30) @(negedge clk);
    check("t5_no_result", 256'(res_cnt), 256'(4));
    check("t5_err_code",  256'(err_code), 256'(2'b11));
    check("t5_err_count", 256'(err_count), 256'(8));
`else
    wait_res(5, "t5_res_cnt");
    check("t5_hash",      res_hash[4], H5);
    check("t5_nonce",     256'(res_nonce[4]), 256'(32'h9ABCDEF0));
    check("t5_err_count", 256'(err_count), 256'(7));
`endif
    check("t5_sat_count", 256'(err_count2), 256'(3));

    // 6: reset with hash idx4 in flight
    base = rd_ptr;
    push_frame(H6, 32'h0F0F0F0F, 8'h00, 0);
    cyc = 0;
    lvl = rd_ptr - base;
    while (lvl != 6'd4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      lvl = rd_ptr - base;
    end
    check("t6_reached_idx4", 256'(lvl), 256'(4));
    rst_n = 1'b0;
    #1;
    check("t6_rst_res_valid", 256'(res_valid), 256'(0));
    check("t6_rst_fifo_rden", 256'(fifo_rden), 256'(0));
    check("t6_rst_hash_out",  hash_out, 256'(0));
    check("t6_rst_nonce_out", 256'(nonce_out), 256'(0));
    check("t6_rst_err_count", 256'(err_count), 256'(0));
    check("t6_rst_err_code",  256'(err_code), 256'(0));
    check("t6_rst_sat_count", 256'(err_count2), 256'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base_cnt = res_cnt;
    push_frame(H7, 32'hCAFEF00D, 8'h00, 0);
    wait_res(base_cnt + 1, "t6_res_cnt");
    check("t6_hash",      res_hash[base_cnt], H7);
    check("t6_nonce",     256'(res_nonce[base_cnt]), 256'(32'hCAFEF00D));
    check("t6_err_count", 256'(err_count), 256'(0));
    for (int i = 0; i < 4; i++) push(48'h710000000000);
    repeat (12) @(negedge clk);
    check("t6_err_count_after", 256'(err_count), 256'(4));
    check("t6_sat_stays",       256'(err_count2), 256'(3));
    check("t6_err_code",        256'(err_code), 256'(2'b01));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
